// File: rtl/tdr_pkg.sv
// rtl/tdr_pkg.sv - shared constants and helper functions for the segmented test data register
//
// Contents:
//   TDR_WIDTH_DEF, TDR_NSEG_DEF : default register width and segment count
//   TDR_POP_MAX                 : widest mask tdr_popcount accepts
//   tdr_clog2()                 : ceiling log2, used to size the length counter
//   tdr_popcount()              : number of set bits, used to derive ACT_LEN

package tdr_pkg;

    localparam int TDR_WIDTH_DEF = 32;
    localparam int TDR_NSEG_DEF  = 4;
    localparam int TDR_POP_MAX   = 64;

    function automatic int tdr_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int tdr_popcount(input logic [TDR_POP_MAX-1:0] vec);
        int count;
        count = 0;
        for (int i = 0; i < TDR_POP_MAX; i++) begin
            if (vec[i]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/tdr_seg_cell.sv
// rtl/tdr_seg_cell.sv - one segment of the segmented test data register
//
// Parameters:
//   SEG_W   : shift bits held by this segment
//   PO_RST  : reset value of this segment's parallel-output slice
// Ports:
//   tclk_i     in   test clock; serial state on posedge, PO slice on negedge
//   tresetn_i  in   asynchronous active-low reset
//   capture_i  in   qualified capture (already excludes a coincident shift)
//   shift_i    in   qualified shift
//   update_i   in   qualified update (enable and, if built in, length check applied)
//   active_i   in   latched active flag for this segment
//   seg_in_i   in   serial input from the next higher segment (or SI)
//   pi_i       in   capture data slice
//   seg_out_o  out  serial output toward the next lower segment (or SO)
//   po_o       out  parallel-output slice

module tdr_seg_cell #(
    parameter int               SEG_W  = 8,
    parameter logic [SEG_W-1:0] PO_RST = '0
) (
    input  logic             tclk_i,
    input  logic             tresetn_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             active_i,
    input  logic             seg_in_i,
    input  logic [SEG_W-1:0] pi_i,
    output logic             seg_out_o,
    output logic [SEG_W-1:0] po_o
);

    logic [SEG_W-1:0] sbits_q, sbits_d;
    logic             byp_q, byp_d;
    logic [SEG_W-1:0] po_q;
    logic [SEG_W-1:0] shifted;

    // A one-bit segment has no upper bits to move down.
    if (SEG_W == 1) begin : g_w1
        assign shifted = seg_in_i;
    end else begin : g_wn
        assign shifted = {seg_in_i, sbits_q[SEG_W-1:1]};
    end

    always_comb begin
        sbits_d = sbits_q;
        byp_d   = byp_q;
        if (shift_i) begin
            // An active segment moves its bits; an inactive one is a single
            // bypass stage and leaves its bits untouched.
            if (active_i) begin
                sbits_d = shifted;
            end else begin
                byp_d = seg_in_i;
            end
        end else if (capture_i) begin
            sbits_d = pi_i;
            byp_d   = 1'b0;
        end
    end

    always_ff @(posedge tclk_i or negedge tresetn_i) begin
        if (!tresetn_i) begin
            sbits_q <= '0;
            byp_q   <= 1'b0;
        end else begin
            sbits_q <= sbits_d;
            byp_q   <= byp_d;
        end
    end

    always_ff @(negedge tclk_i or negedge tresetn_i) begin
        if (!tresetn_i) begin
            po_q <= PO_RST;
        end else if (update_i && active_i) begin
            po_q <= sbits_q;
        end
    end

    assign seg_out_o = active_i ? sbits_q[0] : byp_q;
    assign po_o      = po_q;

endmodule

// File: rtl/tdr_seg.sv
// rtl/tdr_seg.sv - segmented test data register with per-segment bypass
//
// Build option: TDR_LENCHK_EN enables the shift-length check and LEN_ERR.
// Parameters: WIDTH (total bits), NSEG (segments), RESET_VAL (PO reset value).
// Ports:
//   TCLK                       in   test clock
//   TRESETN                    in   asynchronous active-low reset
//   CaptureDR/ShiftDR/UpdateDR in   TAP state strobes
//   Enable                     in   instruction-decoder select
//   SI                         in   serial in
//   PI      [WIDTH]            in   capture data
//   SEG_EN  [NSEG]             in   requested active-segment mask, latched on capture
//   SO                         out  serial out (segment 0 output)
//   PO      [WIDTH]            out  parallel update register
//   LEN_ERR                    out  sticky shift-length error
//   ACT_LEN [CNTW]             out  current chain length

module tdr_seg
    import tdr_pkg::*;
#(
    parameter int               WIDTH     = TDR_WIDTH_DEF,
    parameter int               NSEG      = TDR_NSEG_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEG_W     = WIDTH / NSEG,
    localparam int              CNTW      = tdr_clog2(WIDTH + 2)
) (
    input  logic             TCLK,
    input  logic             TRESETN,
    input  logic             CaptureDR,
    input  logic             ShiftDR,
    input  logic             UpdateDR,
    input  logic             Enable,
    input  logic             SI,
    input  logic [WIDTH-1:0] PI,
    input  logic [NSEG-1:0]  SEG_EN,
    output logic             SO,
    output logic [WIDTH-1:0] PO,
    output logic             LEN_ERR,
    output logic [CNTW-1:0]  ACT_LEN
);

    logic [NSEG-1:0]        mask_q, mask_d;
    logic                   shift_en;
    logic                   capture_en;
    logic                   upd_req;
    logic                   upd_go;
    logic [NSEG:0]          link;
    logic [TDR_POP_MAX-1:0] mask_ext;
    int                     n_act;

    // Shift has priority over a coincident capture.
    assign shift_en   = Enable & ShiftDR;
    assign capture_en = Enable & CaptureDR & ~ShiftDR;
    assign upd_req    = Enable & UpdateDR;

    // The mask only moves on capture so the chain cannot change length mid-shift.
    always_comb begin
        mask_d = mask_q;
        if (capture_en) begin
            mask_d = SEG_EN;
        end
    end

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_ext = TDR_POP_MAX'(mask_q);

    always_comb begin
        n_act   = tdr_popcount(mask_ext);
        ACT_LEN = CNTW'(n_act * SEG_W + (NSEG - n_act));
    end

`ifdef TDR_LENCHK_EN
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH + 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            len_ok;
    logic            len_err_q;

    // The counter exists only to feed the length compare, so it is part of this build alone.
    always_comb begin
        cnt_d = cnt_q;
        if (shift_en) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (capture_en) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign len_ok = (cnt_q == ACT_LEN);

    // Sticky: only a correctly sized update clears it.
    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            len_err_q <= 1'b0;
        end else if (upd_req) begin
            len_err_q <= ~len_ok;
        end
    end

    assign upd_go  = upd_req & len_ok;
    assign LEN_ERR = len_err_q;
`else
    assign upd_go  = upd_req;
    assign LEN_ERR = 1'b0;
`endif

    // link[k+1] feeds segment k, link[k] is its output; SI enters at the top.
    assign link[NSEG] = SI;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        tdr_seg_cell #(
            .SEG_W  (SEG_W),
            .PO_RST (RESET_VAL[k*SEG_W +: SEG_W])
        ) u_cell (
            .tclk_i    (TCLK),
            .tresetn_i (TRESETN),
            .capture_i (capture_en),
            .shift_i   (shift_en),
            .update_i  (upd_go),
            .active_i  (mask_q[k]),
            .seg_in_i  (link[k+1]),
            .pi_i      (PI[k*SEG_W +: SEG_W]),
            .seg_out_o (link[k]),
            .po_o      (PO[k*SEG_W +: SEG_W])
        );
    end

    assign SO = link[0];

endmodule

// File: tb/tb_tdr_seg.sv
// tb/tb_tdr_seg.sv - directed self-checking bench for tdr_seg (WIDTH=32, NSEG=4)

module tb_tdr_seg;

    logic        TCLK;
    logic        TRESETN;
    logic        CaptureDR;
    logic        ShiftDR;
    logic        UpdateDR;
    logic        Enable;
    logic        SI;
    logic [31:0] PI;
    logic [3:0]  SEG_EN;
    wire         SO;
    wire  [31:0] PO;
    wire         LEN_ERR;
    wire  [5:0]  ACT_LEN;

    int vectors     = 0;
    int miscompares = 0;

    tdr_seg #(
        .WIDTH     (32),
        .NSEG      (4),
        .RESET_VAL (32'h12345678)
    ) dut (
        .TCLK      (TCLK),
        .TRESETN   (TRESETN),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .Enable    (Enable),
        .SI        (SI),
        .PI        (PI),
        .SEG_EN    (SEG_EN),
        .SO        (SO),
        .PO        (PO),
        .LEN_ERR   (LEN_ERR),
        .ACT_LEN   (ACT_LEN)
    );

    initial begin
        TCLK = 1'b0;
        forever #5 TCLK = ~TCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge TCLK);
        #1;
    endtask

    task automatic do_capture(input logic [31:0] pi, input logic [3:0] en);
        PI        = pi;
        SEG_EN    = en;
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
    endtask

    task automatic do_shift(input int n, input logic [31:0] data, output logic [31:0] so_bits);
        so_bits = '0;
        for (int i = 0; i < n; i++) begin
            so_bits[i] = SO;
            SI         = data[i];
            ShiftDR    = 1'b1;
            tick();
        end
        ShiftDR = 1'b0;
        SI      = 1'b0;
    endtask

    task automatic do_update();
        UpdateDR = 1'b1;
        @(negedge TCLK);
        #1;
        UpdateDR = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        TRESETN = 1'b0;
        tick();
        tick();
        vectors++;
        if (PO !== 32'h12345678) begin
            $display("FAIL reset_po: got %h want %h", PO, 32'h12345678); miscompares++;
        end
        vectors++;
        if (SO !== 1'b0) begin
            $display("FAIL reset_so: got %b want 0", SO); miscompares++;
        end
        vectors++;
        if (ACT_LEN !== 6'd32) begin
            $display("FAIL reset_act_len: got %0d want 32", ACT_LEN); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL reset_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
        TRESETN = 1'b1;
        tick();
    endtask

    task automatic test_full_chain();
        logic [31:0] so_bits;
        do_capture(32'hA5A50F0F, 4'b1111);
        vectors++;
        if (ACT_LEN !== 6'd32) begin
            $display("FAIL full_act_len: got %0d want 32", ACT_LEN); miscompares++;
        end
        do_shift(32, 32'hDEADBEEF, so_bits);
        vectors++;
        if (so_bits !== 32'hA5A50F0F) begin
            $display("FAIL full_so_stream: got %h want %h", so_bits, 32'hA5A50F0F); miscompares++;
        end
        do_update();
        vectors++;
        if (PO !== 32'hDEADBEEF) begin
            $display("FAIL full_po: got %h want %h", PO, 32'hDEADBEEF); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL full_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
    endtask

    // Chain: SI -> seg3 bypass -> seg2[7:0] -> seg1 bypass -> seg0[7:0] -> SO.
    // After 18 shifts seg0 holds data[7:0] and seg2 holds data[16:9].
    task automatic test_partial_mask();
        logic [31:0] so_bits;
        do_capture(32'h00000000, 4'b0101);
        vectors++;
        if (ACT_LEN !== 6'd18) begin
            $display("FAIL partial_act_len: got %0d want 18", ACT_LEN); miscompares++;
        end
        do_shift(18, 32'h00012D3C, so_bits);
        do_update();
        vectors++;
        if (PO !== 32'hDE96BE3C) begin
            $display("FAIL partial_po: got %h want %h", PO, 32'hDE96BE3C); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL partial_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
    endtask

    task automatic test_short_shift();
        logic [31:0] so_bits;
        do_capture(32'h0F0F00FF, 4'b1111);
        do_shift(31, 32'h13579BDF, so_bits);
        do_update();
`ifdef TDR_LENCHK_EN
        vectors++;
        if (PO !== 32'hDE96BE3C) begin
            $display("FAIL short_po: got %h want %h", PO, 32'hDE96BE3C); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b1) begin
            $display("FAIL short_len_err: got %b want 1", LEN_ERR); miscompares++;
        end
`else
        vectors++;
        if (PO !== 32'h26AF37BE) begin
            $display("FAIL short_po: got %h want %h", PO, 32'h26AF37BE); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL short_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
`endif
        do_capture(32'h00000000, 4'b1111);
        do_shift(32, 32'hCAFEF00D, so_bits);
        vectors++;
        if (so_bits !== 32'h00000000) begin
            $display("FAIL good_so_stream: got %h want %h", so_bits, 32'h00000000); miscompares++;
        end
        do_update();
        vectors++;
        if (PO !== 32'hCAFEF00D) begin
            $display("FAIL good_po: got %h want %h", PO, 32'hCAFEF00D); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL good_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
    endtask

    task automatic test_enable_low();
        logic [31:0] so_bits;
        Enable = 1'b0;
        do_capture(32'hFFFFFFFF, 4'b0011);
        do_shift(32, 32'h55555555, so_bits);
        do_update();
        vectors++;
        if (so_bits !== 32'hFFFFFFFF) begin
            $display("FAIL disabled_so_stream: got %h want %h", so_bits, 32'hFFFFFFFF); miscompares++;
        end
        vectors++;
        if (PO !== 32'hCAFEF00D) begin
            $display("FAIL disabled_po: got %h want %h", PO, 32'hCAFEF00D); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL disabled_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
        vectors++;
        if (ACT_LEN !== 6'd32) begin
            $display("FAIL disabled_act_len: got %0d want 32", ACT_LEN); miscompares++;
        end
        Enable = 1'b1;
        do_shift(32, 32'h00000000, so_bits);
        vectors++;
        if (so_bits !== 32'hCAFEF00D) begin
            $display("FAIL disabled_serial_kept: got %h want %h", so_bits, 32'hCAFEF00D); miscompares++;
        end
    endtask

    // Shift must win over capture; the first data bit goes in on the combined cycle.
    task automatic test_capture_shift_conflict();
        logic [31:0] so_bits;
        logic [31:0] data;
        data = 32'h0BADF00D;
        do_capture(32'h80000002, 4'b1111);
        PI        = 32'h00000000;
        CaptureDR = 1'b1;
        ShiftDR   = 1'b1;
        SI        = data[0];
        tick();
        CaptureDR = 1'b0;
        ShiftDR   = 1'b0;
        vectors++;
        if (SO !== 1'b1) begin
            $display("FAIL conflict_so: got %b want 1", SO); miscompares++;
        end
        do_shift(31, data >> 1, so_bits);
        do_update();
        vectors++;
        if (PO !== 32'h0BADF00D) begin
            $display("FAIL conflict_po: got %h want %h", PO, 32'h0BADF00D); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL conflict_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] so_bits;
        do_capture(32'hFFFFFFFF, 4'b0001);
        vectors++;
        if (ACT_LEN !== 6'd11) begin
            $display("FAIL mid_act_len_before: got %0d want 11", ACT_LEN); miscompares++;
        end
        do_shift(10, 32'h000003FF, so_bits);
        TRESETN = 1'b0;
        #2;
        vectors++;
        if (PO !== 32'h12345678) begin
            $display("FAIL mid_reset_po: got %h want %h", PO, 32'h12345678); miscompares++;
        end
        vectors++;
        if (SO !== 1'b0) begin
            $display("FAIL mid_reset_so: got %b want 0", SO); miscompares++;
        end
        vectors++;
        if (ACT_LEN !== 6'd32) begin
            $display("FAIL mid_reset_act_len: got %0d want 32", ACT_LEN); miscompares++;
        end
        tick();
        TRESETN = 1'b1;
        tick();
        do_update();
`ifdef TDR_LENCHK_EN
        vectors++;
        if (PO !== 32'h12345678) begin
            $display("FAIL post_reset_po: got %h want %h", PO, 32'h12345678); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b1) begin
            $display("FAIL post_reset_len_err: got %b want 1", LEN_ERR); miscompares++;
        end
`else
        vectors++;
        if (PO !== 32'h00000000) begin
            $display("FAIL post_reset_po: got %h want %h", PO, 32'h00000000); miscompares++;
        end
        vectors++;
        if (LEN_ERR !== 1'b0) begin
            $display("FAIL post_reset_len_err: got %b want 0", LEN_ERR); miscompares++;
        end
`endif
    endtask

    initial begin
        TRESETN   = 1'b0;
        CaptureDR = 1'b0;
        ShiftDR   = 1'b0;
        UpdateDR  = 1'b0;
        Enable    = 1'b1;
        SI        = 1'b0;
        PI        = '0;
        SEG_EN    = '0;
        test_reset();
        test_full_chain();
        test_partial_mask();
        test_short_shift();
        test_enable_low();
        test_capture_shift_conflict();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
